uart_arb: RTL and testbench
===========================

Name: uart_arb

Overview:
- Front-end controller for the uart core. It shares the single transmitter between two byte requesters using round-robin arbitration, and sequences the core's write_data/buf_empty handshake.
- Drains received bytes from the core's new_data/read_data interface into a small RX FIFO for one consumer.
- Sits between the uart core and the CPU/debug logic; all logic runs in the uart_clk domain.

Parameters:
- RX_AW, 2, RX FIFO address width; depth = 2**RX_AW entries (4 by default).

Ports:
- uart_clk  input  1  clock
- reset  input  1  asynchronous, active-high reset
- tx0_data  input  8  byte from requester 0
- tx0_valid  input  1  requester 0 has a byte; must hold valid and data stable until tx0_ready
- tx0_ready  output  1  one-cycle accept strobe for requester 0
- tx1_data  input  8  byte from requester 1
- tx1_valid  input  1  as tx0_valid
- tx1_ready  output  1  as tx0_ready
- rx_data  output  8  head of RX FIFO, valid when rx_valid=1
- rx_valid  output  1  RX FIFO not empty
- rx_ready  input  1  consumer pop; pops when rx_valid & rx_ready
- rx_count  output  RX_AW+1  current RX FIFO occupancy
- busy  output  1  TX state is not IDLE
- last_grant  output  1  index of the most recently granted TX requester
- u_data_in  output  8  to uart data_in
- u_write_data  output  1  to uart write_data
- u_buf_empty  input  1  from uart buf_empty
- u_data_out  input  8  from uart data_out
- u_new_data  input  1  from uart new_data
- u_read_data  output  1  to uart read_data

Behaviour:
- Clock and reset: already decided — reset is asynchronous, active-high; clock is uart_clk. All state is flopped on posedge uart_clk or posedge reset.
- Reset values:
  - TX state = IDLE; grant = 0; last_grant = 1, so port 0 wins first.
  - RX FIFO empty: rx_count = 0, rx_valid = 0, rx_data = 0.
  - u_write_data = 0, u_read_data = 0, tx0_ready = tx1_ready = 0, busy = 0.
- TX state machine, states IDLE, ISSUE, SEND:
  - IDLE: if u_buf_empty=1 and any txN_valid=1, pick the winner, register it in grant, and go to ISSUE next cycle.
    - If only one port is valid, that port wins.
    - If both are valid, the winner is ~last_grant.
    - If u_buf_empty=0, stay in IDLE. This covers a transfer started elsewhere.
  - ISSUE (exactly 1 cycle):
    - u_write_data=1; u_data_in = tx[grant]_data; tx[grant]_ready=1.
    - The other ready stays 0.
    - last_grant <= grant. Go to SEND.
  - SEND: wait for u_buf_empty=1, then go to IDLE. The uart clears buf_empty on the ISSUE edge, so SEND spans the whole 10-bit frame.
  - u_data_in holds the last issued byte outside ISSUE. u_write_data is 0 in every state except ISSUE.
- TX latency: valid seen in IDLE -> ready/write on the next cycle. Back-to-back bytes are separated by a full frame plus 2 cycles (SEND->IDLE->ISSUE).
- Fairness: with both ports valid continuously, grants alternate 0,1,0,1.
- Requester rule: a requester that drops valid while waiting is simply not granted. Valid dropping during ISSUE is a protocol violation; the byte is still sent.
- RX path:
  - u_read_data = u_new_data & ~full (combinational).
  - The same cycle pushes u_data_out into the FIFO.
  - The uart clears new_data on the next edge, so each byte is pushed exactly once.
- RX FIFO:
  - Synchronous circular buffer; pointers are RX_AW bits and wrap modulo depth.
  - rx_data is the head entry, shown combinationally.
  - Simultaneous push and pop: occupancy unchanged; both pointers advance.
  - When full, push is blocked even if a pop occurs that cycle.
  - Pop while empty is ignored.
- Reset mid-operation: asserting reset during SEND or ISSUE returns to IDLE immediately. Any byte the uart is already sending is abandoned from the arbiter's view. FIFO contents are lost.

Optional Feature:
- Macro: UART_ARB_RX_OVERRUN_EN.
- Defined:
  - Adds output rx_overrun_cnt [7:0], reset to 0.
  - When u_new_data=1 and the FIFO is full, u_read_data=1 anyway and the byte is discarded.
  - rx_overrun_cnt increments and saturates at 255.
- Not defined:
  - No counter port.
  - When full, u_read_data stays 0 and the byte waits in the uart until space frees. A later reception may overwrite it inside the uart.

Test Plan:
- Reset, then tx0_valid=1, tx0_data=8'hA5, u_buf_empty=1 -> ISSUE next cycle: u_write_data=1, u_data_in=A5, tx0_ready=1 for exactly 1 cycle; busy until the uart model raises u_buf_empty.
- tx0 and tx1 held valid (8'h11, 8'h22) for 4 grants -> bytes on u_data_in in order 11,22,11,22; last_grant toggles each grant.
- tx1_valid=1 while u_buf_empty=0 for 50 cycles -> no u_write_data; issue occurs 1 cycle after u_buf_empty returns to 1.
- Pulse u_new_data with u_data_out=01,02,03,04, rx_ready=0 -> rx_count=4, u_read_data pulsed 4 times; then pop 4 -> rx_data=01,02,03,04 in order, rx_valid=0.
- FIFO full, then u_new_data=1 with u_data_out=8'h55:
  - Without the macro: u_read_data stays 0 until one pop, then 55 is pushed.
  - With the macro: rx_overrun_cnt=1 and the FIFO is unchanged.
- Assert reset during SEND with the FIFO holding 2 entries -> busy=0, rx_valid=0, rx_count=0, u_write_data=0 on the reset edge.

Source files
------------

// File: rtl/uart_arb.sv
// uart_arb: front end for the uart core.
//   TX: round-robin arbiter between two byte requesters, sequencing the
//       core's write_data / buf_empty handshake (IDLE -> ISSUE -> SEND).
//   RX: drains new_data/read_data bytes into a 2**RX_AW entry FIFO.
// Handshakes: txN_valid/txN_data must stay stable until the one-cycle txN_ready
//   strobe; an RX byte is popped on any cycle where rx_valid & rx_ready.
// Optional feature macro: UART_ARB_RX_OVERRUN_EN (discard-on-full plus a
//   saturating rx_overrun_cnt). Default build blocks reads while full.
// tx_state exposes the TX FSM state for debug.
module uart_arb #(
    parameter int RX_AW = 2
) (
    input  logic             uart_clk,
    input  logic             reset,
    input  logic [7:0]       tx0_data,
    input  logic             tx0_valid,
    output logic             tx0_ready,
    input  logic [7:0]       tx1_data,
    input  logic             tx1_valid,
    output logic             tx1_ready,
    output logic [7:0]       rx_data,
    output logic             rx_valid,
    input  logic             rx_ready,
    output logic [RX_AW:0]   rx_count,
    output logic             busy,
    output logic             last_grant,
    output logic [7:0]       u_data_in,
    output logic             u_write_data,
    input  logic             u_buf_empty,
    input  logic [7:0]       u_data_out,
    input  logic             u_new_data,
    output logic             u_read_data,
`ifdef UART_ARB_RX_OVERRUN_EN
    output logic [7:0]       rx_overrun_cnt,
`endif
    output logic [1:0]       tx_state
);

    localparam int DEPTH = 1 << RX_AW;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        SEND  = 2'd2
    } tx_state_e;

    tx_state_e   state_q, state_d;
    logic        grant_q, grant_d;
    logic        last_grant_q, last_grant_d;
    logic [7:0]  data_in_q, data_in_d;
    logic [7:0]  issue_byte;

    logic [RX_AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [RX_AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [RX_AW:0]   count_q, count_d;
    logic [7:0]       mem_q [DEPTH];
    logic [7:0]       mem_d [DEPTH];
    logic             full;
    logic             push;
    logic             pop;

    // TX state, grant and held output byte registers
    always_ff @(posedge uart_clk or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            grant_q      <= 1'b0;
            last_grant_q <= 1'b1;
            data_in_q    <= 8'h00;
        end else begin
            state_q      <= state_d;
            grant_q      <= grant_d;
            last_grant_q <= last_grant_d;
            data_in_q    <= data_in_d;
        end
    end

    assign issue_byte = grant_q ? tx1_data : tx0_data;

    // TX next state: arbitrate in IDLE, strobe for one cycle in ISSUE, wait out the frame in SEND
    always_comb begin
        state_d      = state_q;
        grant_d      = grant_q;
        last_grant_d = last_grant_q;
        data_in_d    = data_in_q;
        case (state_q)
            IDLE: begin
                if (u_buf_empty && (tx0_valid || tx1_valid)) begin
                    if (tx0_valid && tx1_valid) begin
                        grant_d = ~last_grant_q;
                    end else begin
                        grant_d = tx1_valid;
                    end
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                data_in_d    = issue_byte;
                last_grant_d = grant_q;
                state_d      = SEND;
            end
            SEND: begin
                if (u_buf_empty) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign u_write_data = (state_q == ISSUE);
    assign u_data_in    = (state_q == ISSUE) ? issue_byte : data_in_q;
    assign tx0_ready    = (state_q == ISSUE) && !grant_q;
    assign tx1_ready    = (state_q == ISSUE) && grant_q;
    assign busy         = (state_q != IDLE);
    assign last_grant   = last_grant_q;
    assign tx_state     = state_q;

    // RX FIFO: a full FIFO refuses a push even when a pop happens the same cycle
    assign full     = (count_q == (RX_AW+1)'(DEPTH));
    assign push     = u_new_data && !full;
    assign pop      = (count_q != '0) && rx_ready;
    assign rx_valid = (count_q != '0);
    assign rx_count = count_q;
    assign rx_data  = rx_valid ? mem_q[rd_ptr_q] : 8'h00;

`ifdef UART_ARB_RX_OVERRUN_EN
    logic [7:0] ovr_q, ovr_d;

    assign u_read_data    = u_new_data;
    assign rx_overrun_cnt = ovr_q;

    // Overrun counter: counts bytes discarded because the FIFO was full
    always_ff @(posedge uart_clk or posedge reset) begin
        if (reset) begin
            ovr_q <= 8'h00;
        end else begin
            ovr_q <= ovr_d;
        end
    end

    // Overrun next value, saturating at 255
    always_comb begin
        ovr_d = ovr_q;
        if (u_new_data && full && (ovr_q != 8'hFF)) begin
            ovr_d = ovr_q + 8'd1;
        end
    end
`else
    assign u_read_data = push;
`endif

    // RX FIFO storage and pointer registers
    always_ff @(posedge uart_clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= 8'h00;
            end
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= mem_d[i];
            end
        end
    end

    // RX FIFO next state: write at tail, advance pointers, track occupancy
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) begin
            mem_d[wr_ptr_q] = u_data_out;
            wr_ptr_d        = wr_ptr_q + RX_AW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + RX_AW'(1);
        end
        case ({push, pop})
            2'b10:   count_d = count_q + (RX_AW+1)'(1);
            2'b01:   count_d = count_q - (RX_AW+1)'(1);
            default: count_d = count_q;
        endcase
    end

endmodule

// File: tb/tb_uart_arb.sv
// Testbench for uart_arb: uart model (buf_empty frame timer), TX issue
// scoreboard, table-driven RX FIFO vectors, hand sequences for TX corners.
module tb_uart_arb;

    localparam int FRAME = 10;

    logic       uart_clk = 1'b0;
    logic       reset = 1'b1;
    logic [7:0] tx0_data = 8'h00;
    logic       tx0_valid = 1'b0;
    logic       tx0_ready;
    logic [7:0] tx1_data = 8'h00;
    logic       tx1_valid = 1'b0;
    logic       tx1_ready;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_ready = 1'b0;
    logic [2:0] rx_count;
    logic       busy;
    logic       last_grant;
    logic [7:0] u_data_in;
    logic       u_write_data;
    logic       u_buf_empty;
    logic [7:0] u_data_out = 8'h00;
    logic       u_new_data = 1'b0;
    logic       u_read_data;
    logic [1:0] tx_state;
`ifdef UART_ARB_RX_OVERRUN_EN
    logic [7:0] rx_overrun_cnt;
`endif

    int   tests = 0;
    int   fails = 0;
    int   frame_cnt = 0;
    logic force_busy = 1'b0;
    logic lg_pending = 1'b0;
    logic lg_exp = 1'b0;
    logic [8:0] exp_q[$];

    assign u_buf_empty = (frame_cnt == 0) && !force_busy;

    uart_arb #(.RX_AW(2)) dut (
        .uart_clk(uart_clk), .reset(reset),
        .tx0_data(tx0_data), .tx0_valid(tx0_valid), .tx0_ready(tx0_ready),
        .tx1_data(tx1_data), .tx1_valid(tx1_valid), .tx1_ready(tx1_ready),
        .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
        .rx_count(rx_count), .busy(busy), .last_grant(last_grant),
        .u_data_in(u_data_in), .u_write_data(u_write_data),
        .u_buf_empty(u_buf_empty), .u_data_out(u_data_out),
        .u_new_data(u_new_data), .u_read_data(u_read_data),
`ifdef UART_ARB_RX_OVERRUN_EN
        .rx_overrun_cnt(rx_overrun_cnt),
`endif
        .tx_state(tx_state)
    );

    // clock / watchdog
    always #5 uart_clk = ~uart_clk;

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // uart model + TX scoreboard, sampled on the falling edge
    always @(negedge uart_clk) begin
        if (reset) begin
            frame_cnt  = 0;
            lg_pending = 1'b0;
        end else begin
            if (lg_pending) begin
                check("last_grant_after_issue", last_grant, lg_exp);
                lg_pending = 1'b0;
            end
            if (u_write_data) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_write", 1, 0);
                end else begin
                    logic [8:0] e;
                    e = exp_q.pop_front();
                    check("issue_byte", u_data_in, e[7:0]);
                    check("issue_ready0", tx0_ready, !e[8]);
                    check("issue_ready1", tx1_ready, e[8]);
                    lg_exp     = e[8];
                    lg_pending = 1'b1;
                end
                frame_cnt = FRAME;
            end else if (frame_cnt > 0) begin
                frame_cnt--;
            end
        end
    end

    // driver tasks
    task automatic do_reset();
        @(negedge uart_clk);
        reset = 1'b1;
        tx0_valid = 1'b0; tx1_valid = 1'b0;
        u_new_data = 1'b0; rx_ready = 1'b0; force_busy = 1'b0;
        exp_q.delete();
        repeat (2) @(negedge uart_clk);
        reset = 1'b0;
    endtask

    task automatic wait_idle(input string name);
        int n;
        n = 0;
        while (busy && n < 100) begin
            @(negedge uart_clk); #1;
            n++;
        end
        check(name, busy, 0);
    endtask

    typedef struct {
        logic       nd;
        logic [7:0] dout;
        logic       rdy;
        logic       exp_rd;
        logic       exp_val;
        logic [7:0] exp_data;
        logic [2:0] exp_cnt;
        logic [7:0] exp_ovr;
    } rx_vec_t;

    rx_vec_t vecs[$];

    function automatic void add(input logic nd, input logic [7:0] dout, input logic rdy,
                                input logic rd, input logic val, input logic [7:0] data,
                                input logic [2:0] cnt, input logic [7:0] ovr);
        vecs.push_back('{nd, dout, rdy, rd, val, data, cnt, ovr});
    endfunction

    initial begin
        int cyc;
        int wcount;

        // reset state (reset is held from time 0)
        #12;
        check("rst_busy", busy, 0);
        check("rst_write", u_write_data, 0);
        check("rst_read", u_read_data, 0);
        check("rst_rx_valid", rx_valid, 0);
        check("rst_rx_count", rx_count, 0);
        check("rst_rx_data", rx_data, 0);
        check("rst_ready0", tx0_ready, 0);
        check("rst_ready1", tx1_ready, 0);
        check("rst_last_grant", last_grant, 1);
        check("rst_state", tx_state, 0);
        @(negedge uart_clk);
        reset = 1'b0;

        // single byte from requester 0
        @(negedge uart_clk);
        tx0_data = 8'hA5; tx0_valid = 1'b1;
        exp_q.push_back({1'b0, 8'hA5});
        #1;
        check("t1_idle_no_write", u_write_data, 0);
        @(negedge uart_clk); #1;
        check("t1_write", u_write_data, 1);
        check("t1_data", u_data_in, 8'hA5);
        check("t1_ready0", tx0_ready, 1);
        check("t1_busy", busy, 1);
        @(negedge uart_clk);
        tx0_valid = 1'b0;
        #1;
        check("t1_ready_one_cycle", tx0_ready, 0);
        check("t1_write_one_cycle", u_write_data, 0);
        check("t1_data_hold", u_data_in, 8'hA5);
        check("t1_busy_send", busy, 1);
        cyc = 1;
        while (busy && cyc < 40) begin
            @(negedge uart_clk); #1;
            cyc++;
        end
        check("t1_busy_cycles", cyc, FRAME + 1);
        check("t1_buf_empty_at_idle", u_buf_empty, 1);

        // fairness with both requesters always valid
        do_reset();
        @(negedge uart_clk);
        tx0_data = 8'h11; tx0_valid = 1'b1;
        tx1_data = 8'h22; tx1_valid = 1'b1;
        exp_q.push_back({1'b0, 8'h11});
        exp_q.push_back({1'b1, 8'h22});
        exp_q.push_back({1'b0, 8'h11});
        exp_q.push_back({1'b1, 8'h22});
        cyc = 0;
        while (exp_q.size() != 0 && cyc < 200) begin
            @(negedge uart_clk); #1;
            cyc++;
        end
        check("t2_four_grants", exp_q.size(), 0);
        @(negedge uart_clk);
        tx0_valid = 1'b0; tx1_valid = 1'b0;
        #1;
        check("t2_last_grant", last_grant, 1);
        wait_idle("t2_idle");

        // requester 1 blocked while the uart is busy elsewhere
        @(negedge uart_clk);
        force_busy = 1'b1;
        tx1_data = 8'h3C; tx1_valid = 1'b1;
        wcount = 0;
        repeat (50) begin
            @(negedge uart_clk); #1;
            if (u_write_data) wcount++;
        end
        check("t3_no_write_while_busy", wcount, 0);
        check("t3_stays_idle", busy, 0);
        @(negedge uart_clk);
        force_busy = 1'b0;
        exp_q.push_back({1'b1, 8'h3C});
        #1;
        check("t3_no_write_same_cycle", u_write_data, 0);
        @(negedge uart_clk); #1;
        check("t3_write_next_cycle", u_write_data, 1);
        check("t3_ready1", tx1_ready, 1);
        @(negedge uart_clk);
        tx1_valid = 1'b0;
        wait_idle("t3_idle");

        // RX FIFO vectors (expected outputs are pre-edge values for that cycle)
        add(1, 8'h01, 0, 1, 0, 8'h00, 0, 0);
        add(1, 8'h02, 0, 1, 1, 8'h01, 1, 0);
        add(1, 8'h03, 0, 1, 1, 8'h01, 2, 0);
        add(1, 8'h04, 0, 1, 1, 8'h01, 3, 0);
        add(0, 8'h00, 0, 0, 1, 8'h01, 4, 0);
        add(0, 8'h00, 1, 0, 1, 8'h01, 4, 0);
        add(0, 8'h00, 1, 0, 1, 8'h02, 3, 0);
        add(0, 8'h00, 1, 0, 1, 8'h03, 2, 0);
        add(0, 8'h00, 1, 0, 1, 8'h04, 1, 0);
        add(0, 8'h00, 0, 0, 0, 8'h00, 0, 0);
        add(1, 8'hAA, 1, 1, 0, 8'h00, 0, 0);
        add(1, 8'hBB, 1, 1, 1, 8'hAA, 1, 0);
        add(0, 8'h00, 0, 0, 1, 8'hBB, 1, 0);
        add(0, 8'h00, 1, 0, 1, 8'hBB, 1, 0);
        add(0, 8'h00, 0, 0, 0, 8'h00, 0, 0);
        add(1, 8'h10, 0, 1, 0, 8'h00, 0, 0);
        add(1, 8'h20, 0, 1, 1, 8'h10, 1, 0);
        add(1, 8'h30, 0, 1, 1, 8'h10, 2, 0);
        add(1, 8'h40, 0, 1, 1, 8'h10, 3, 0);
`ifdef UART_ARB_RX_OVERRUN_EN
        add(1, 8'h55, 0, 1, 1, 8'h10, 4, 0);
        add(0, 8'h00, 0, 0, 1, 8'h10, 4, 1);
        add(0, 8'h00, 1, 0, 1, 8'h10, 4, 1);
        add(0, 8'h00, 0, 0, 1, 8'h20, 3, 1);
`else
        add(1, 8'h55, 0, 0, 1, 8'h10, 4, 0);
        add(1, 8'h55, 1, 0, 1, 8'h10, 4, 0);
        add(1, 8'h55, 0, 1, 1, 8'h20, 3, 0);
        add(0, 8'h00, 1, 0, 1, 8'h20, 4, 0);
        add(0, 8'h00, 1, 0, 1, 8'h30, 3, 0);
        add(0, 8'h00, 1, 0, 1, 8'h40, 2, 0);
        add(0, 8'h00, 0, 0, 1, 8'h55, 1, 0);
`endif
        for (int i = 0; i < vecs.size(); i++) begin
            @(negedge uart_clk);
            u_new_data = vecs[i].nd;
            u_data_out = vecs[i].dout;
            rx_ready   = vecs[i].rdy;
            #1;
            check($sformatf("rx%0d_read", i), u_read_data, vecs[i].exp_rd);
            check($sformatf("rx%0d_valid", i), rx_valid, vecs[i].exp_val);
            check($sformatf("rx%0d_data", i), rx_data, vecs[i].exp_data);
            check($sformatf("rx%0d_count", i), rx_count, vecs[i].exp_cnt);
`ifdef UART_ARB_RX_OVERRUN_EN
            check($sformatf("rx%0d_ovr", i), rx_overrun_cnt, vecs[i].exp_ovr);
`endif
        end
        @(negedge uart_clk);
        u_new_data = 1'b0; rx_ready = 1'b0;

        // reset during SEND with two bytes in the RX FIFO
        do_reset();
        @(negedge uart_clk);
        u_new_data = 1'b1; u_data_out = 8'h61;
        @(negedge uart_clk);
        u_data_out = 8'h62;
        @(negedge uart_clk);
        u_new_data = 1'b0;
        tx0_data = 8'h77; tx0_valid = 1'b1;
        exp_q.push_back({1'b0, 8'h77});
        #1;
        check("t5_fifo_two", rx_count, 2);
        cyc = 0;
        while (!tx0_ready && cyc < 5) begin
            @(negedge uart_clk); #1;
            cyc++;
        end
        check("t5_issued", tx0_ready, 1);
        @(negedge uart_clk);
        tx0_valid = 1'b0;
        #1;
        check("t5_in_send", tx_state, 2);
        #2;
        reset = 1'b1;
        #1;
        check("t5_rst_busy", busy, 0);
        check("t5_rst_rx_valid", rx_valid, 0);
        check("t5_rst_rx_count", rx_count, 0);
        check("t5_rst_write", u_write_data, 0);
        check("t5_rst_state", tx_state, 0);
        @(negedge uart_clk);
        @(negedge uart_clk);
        reset = 1'b0;
        repeat (2) @(negedge uart_clk);

        // final report
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
